uart_reception: RTL and testbench

//  - UART receiver (8N1, LSB first) that brings host commands into the FPGA, e.g. gesture-sensor mode select and re-init requests.
//  - Counterpart of the existing 9600-baud UART transmitter; sits between the Rx pin and the command/control logic.
//  - Provides 16x oversampling with majority vote, start-glitch rejection, framing-error and overrun detection, and a level-valid/ack handshake.

---
 rtl/uart_reception_pkg.sv | 32 +++
 rtl/uart_baud_tick.sv | 39 +++
 rtl/uart_reception.sv | 177 +++++++++++++++++
 tb/tb_uart_reception.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_reception_pkg.sv
// Shared UART constants: line-rate defaults, oversampling points and receiver state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_reception_pkg;

    localparam int unsigned CLK_FREQ_HZ = 50_000_000;
    localparam int unsigned BAUD        = 9600;
    localparam int unsigned OVERSAMPLE  = 16;

    // Clocks per oversample tick, rounded to nearest.
    function automatic int unsigned calc_tick_div(input int unsigned clk_hz, input int unsigned baud);
        int unsigned per_tick;
        per_tick = baud * OVERSAMPLE;
        return (clk_hz + per_tick / 2) / per_tick;
    endfunction

    localparam int unsigned TICK_DIV = calc_tick_div(CLK_FREQ_HZ, BAUD);

    // Sample-counter points within one bit: three votes around mid-bit, decided on the last.
    localparam logic [3:0] S_VOTE_A = 4'd7;
    localparam logic [3:0] S_VOTE_B = 4'd8;
    localparam logic [3:0] S_DECIDE = 4'd9;

    typedef enum logic [2:0] {
        S_WAIT_IDLE = 3'd0,
        S_IDLE      = 3'd1,
        S_START     = 3'd2,
        S_DATA      = 3'd3,
        S_STOP      = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: free-running divider, one-clock tick on wrap, re-phased by Clear_i.
// Latency: first tick TICK_DIV clocks after a clear.
// Backpressure: none; the tick is a pure timing strobe.
module uart_baud_tick #(
    parameter int unsigned TICK_DIV = uart_reception_pkg::TICK_DIV
) (
    input  logic Clk_i,
    input  logic Reset_i,
    input  logic Clear_i,
    output logic Tick_o
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             wrap;

    // Next count: wrap at CNT_MAX, restart from zero on clear so ticks align to the clear.
    always_comb begin
        wrap   = (cnt_q == CNT_MAX);
        cnt_d  = cnt_q + CNT_W'(1);
        Tick_o = wrap && !Clear_i;
        if (wrap || Clear_i) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_reception.sv
// 8N1 UART receiver with 16x oversampling, 3-sample majority vote, glitch/framing/overrun detection.
// Latency: Data_Available_o rises 1 clk after the stop-bit decision tick (plus 2 clk input synchronizer).
// Backpressure: none on the line; an unacked byte is held and newer bytes are dropped with Overrun_o set.
module uart_reception #(
    parameter int unsigned CLK_FREQ_HZ = uart_reception_pkg::CLK_FREQ_HZ,
    parameter int unsigned BAUD        = uart_reception_pkg::BAUD
) (
    input  logic       Clk_i,
    input  logic       Reset_i,
    input  logic       Rx_i,
    input  logic       Data_Ack_i,
    output logic [7:0] Data_o,
    output logic       Data_Available_o,
    output logic       Framing_Error_o,
    output logic       Overrun_o,
    output logic       Busy_o
);

    import uart_reception_pkg::*;

    localparam int unsigned RX_TICK_DIV = calc_tick_div(CLK_FREQ_HZ, BAUD);

    // Input synchronizer and edge history.
    logic       rx_meta_q;
    logic       rxs_q;
    logic       rxs_prev_q;
    // Marks when rxs_q reflects the pin rather than its reset value.
    logic [1:0] sync_fill_q;

    rx_state_e  state_q, state_d;
    logic [3:0] s_q, s_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [1:0] votes_q, votes_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_q, data_d;
    logic       avail_q, avail_d;
    logic       ovr_q, ovr_d;
    logic       ferr_q, ferr_d;

    logic       tick;
    logic       clear;
    logic       deliver;
    logic       vote;
    logic [3:0] s_inc;

    uart_baud_tick #(
        .TICK_DIV (RX_TICK_DIV)
    ) u_baud_tick (
        .Clk_i   (Clk_i),
        .Reset_i (Reset_i),
        .Clear_i (clear),
        .Tick_o  (tick)
    );

    // Frame FSM, sample voting, shift register and consumer handshake.
    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        bit_idx_d = bit_idx_q;
        votes_d   = votes_q;
        shift_d   = shift_q;
        data_d    = data_q;
        avail_d   = avail_q;
        ovr_d     = ovr_q;
        ferr_d    = 1'b0;
        clear     = 1'b0;
        deliver   = 1'b0;
        s_inc     = s_q + 4'd1;
        vote      = (votes_q[1] & votes_q[0]) | (votes_q[1] & rxs_q) | (votes_q[0] & rxs_q);

        case (state_q)
            S_WAIT_IDLE: begin
                // Only a genuinely high line (not the synchronizer's reset value) re-arms reception.
                if (sync_fill_q[1] && rxs_q) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (rxs_prev_q && !rxs_q) begin
                    state_d = S_START;
                    s_d     = 4'd0;
                    clear   = 1'b1;
                end
            end
            S_START, S_DATA, S_STOP: begin
                if (tick) begin
                    s_d = s_inc;
                    if (s_inc == S_VOTE_A) votes_d[1] = rxs_q;
                    if (s_inc == S_VOTE_B) votes_d[0] = rxs_q;
                    if (s_inc == S_DECIDE) begin
                        if (state_q == S_START) begin
                            // A start bit that is high at mid-bit was a glitch.
                            if (vote) begin
                                state_d = S_IDLE;
                            end else begin
                                state_d   = S_DATA;
                                bit_idx_d = 3'd0;
                            end
                        end else if (state_q == S_DATA) begin
                            shift_d = {vote, shift_q[7:1]};
                            if (bit_idx_q == 3'd7) begin
                                state_d = S_STOP;
                            end else begin
                                bit_idx_d = bit_idx_q + 3'd1;
                            end
                        end else begin
                            // Leave at mid-stop so the next start edge is never missed.
                            if (vote) begin
                                deliver = 1'b1;
                                state_d = S_IDLE;
                            end else begin
                                ferr_d  = 1'b1;
                                state_d = S_WAIT_IDLE;
                            end
                        end
                    end
                end
            end
            default: begin
                state_d = S_WAIT_IDLE;
            end
        endcase

        if (deliver) begin
            if (!avail_q || Data_Ack_i) begin
                data_d  = shift_d;
                avail_d = 1'b1;
                ovr_d   = ovr_q && !Data_Ack_i;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (Data_Ack_i && avail_q) begin
            avail_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    // State, datapath and synchronizer registers.
    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            rx_meta_q   <= 1'b1;
            rxs_q       <= 1'b1;
            rxs_prev_q  <= 1'b1;
            sync_fill_q <= 2'b00;
            state_q     <= S_WAIT_IDLE;
            s_q         <= 4'd0;
            bit_idx_q   <= 3'd0;
            votes_q     <= 2'b00;
            shift_q     <= 8'h00;
            data_q      <= 8'h00;
            avail_q     <= 1'b0;
            ovr_q       <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            rx_meta_q   <= Rx_i;
            rxs_q       <= rx_meta_q;
            rxs_prev_q  <= rxs_q;
            sync_fill_q <= {sync_fill_q[0], 1'b1};
            state_q     <= state_d;
            s_q         <= s_d;
            bit_idx_q   <= bit_idx_d;
            votes_q     <= votes_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            avail_q     <= avail_d;
            ovr_q       <= ovr_d;
            ferr_q      <= ferr_d;
        end
    end

    assign Data_o           = data_q;
    assign Data_Available_o = avail_q;
    assign Overrun_o        = ovr_q;
    assign Framing_Error_o  = ferr_q;
    assign Busy_o           = (state_q != S_WAIT_IDLE) && (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_reception.sv
// Directed + random bench for the UART receiver, scaled to 4 clocks per tick (64 clocks per bit).
// Latency: frames take 640 clocks; checks happen on the falling clock edge.
// Backpressure: the bench acts as the consumer and decides when to ack.
module tb_uart_reception;

    localparam int unsigned TD        = 4;
    localparam int unsigned BIT_CLK   = 16 * TD;
    localparam real         CLK_P     = 10.0;
    localparam real         BIT_T     = BIT_CLK * CLK_P;
    localparam int unsigned SYNC_CLKS = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       ack;
    logic [7:0] data;
    logic       avail, ferr, ovr, busy;

    int checks = 0;
    int errors = 0;

    // Reference consumer-side state.
    logic [7:0] exp_data;
    logic       exp_avail, exp_ovr;

    // Monitors.
    int fe_cnt = 0;
    int fe_long = 0;
    bit fe_prev = 0;
    bit busy_seen = 0;

    always #(CLK_P / 2) clk = ~clk;

    uart_reception #(
        .CLK_FREQ_HZ (4_000_000),
        .BAUD        (62_500)
    ) dut (
        .Clk_i            (clk),
        .Reset_i          (rst),
        .Rx_i             (rx),
        .Data_Ack_i       (ack),
        .Data_o           (data),
        .Data_Available_o (avail),
        .Framing_Error_o  (ferr),
        .Overrun_o        (ovr),
        .Busy_o           (busy)
    );

    always @(negedge clk) begin
        if (ferr) fe_cnt++;
        if (ferr && fe_prev) fe_long++;
        fe_prev = ferr;
        if (busy) busy_seen = 1;
    end

    initial begin
        #800000;
        $display("FAIL watchdog observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_data = 8'h00; exp_avail = 0; exp_ovr = 0;
    endtask

    task automatic model_deliver(input logic [7:0] b, input bit ack_same);
        if (!exp_avail || ack_same) begin
            exp_data = b; exp_avail = 1; exp_ovr = 0;
        end else begin
            exp_ovr = 1;
        end
    endtask

    task automatic model_ack();
        if (exp_avail) begin
            exp_avail = 0; exp_ovr = 0;
        end
    endtask

    task automatic check_model(input string tag);
        @(negedge clk);
        check({tag, "_data"}, data, exp_data);
        check({tag, "_avail"}, avail, exp_avail);
        check({tag, "_ovr"}, ovr, exp_ovr);
    endtask

    // Drive one frame; leaves the line at the stop-bit level.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input real bit_t);
        rx = 1'b0;
        #(bit_t);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(bit_t);
        end
        rx = stop_ok;
        #(bit_t);
    endtask

    task automatic send_at(input logic [7:0] b, input bit stop_ok, input real bit_t);
        @(posedge clk);
        #1;
        send_frame(b, stop_ok, bit_t);
    endtask

    task automatic do_ack();
        @(posedge clk);
        #1 ack = 1'b1;
        @(posedge clk);
        #1 ack = 1'b0;
    endtask

    task automatic wait_avail(input int lim, output bit ok);
        ok = 0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (avail) begin
                ok = 1;
                break;
            end
        end
    endtask

    initial begin
        logic [7:0] bytes[$];
        logic [7:0] b;
        bit ok;
        int n;
        bit ack_now;

        rst = 1'b1; rx = 1'b1; ack = 1'b0;
        model_reset();
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_data", data, 8'h00);
        check("rst_avail", avail, 1'b0);
        check("rst_ferr", ferr, 1'b0);
        check("rst_ovr", ovr, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        repeat (10) @(posedge clk);

        // 1. single byte, latency window, ack
        n = 0; ok = 0;
        fork
            send_at(8'hA5, 1'b1, BIT_T);
            begin
                @(posedge clk);
                while (!ok && n < 900) begin
                    @(negedge clk);
                    n++;
                    if (avail) ok = 1;
                end
            end
        join
        check("t1_arrived", ok, 1'b1);
        check("t1_latency_in_window",
              (n >= 9 * BIT_CLK + 9 * TD + SYNC_CLKS) && (n <= 9 * BIT_CLK + 9 * TD + SYNC_CLKS + 4), 1'b1);
        model_deliver(8'hA5, 0);
        check_model("t1");
        check("t1_ferr", fe_cnt, 0);
        do_ack(); model_ack();
        check_model("t1_ack");

        // 2. back-to-back frames, each acked on arrival
        bytes = '{8'h00, 8'hFF, 8'h55};
        for (int i = 0; i < 3; i++) bytes.push_back(8'($urandom));
        fork
            begin
                @(posedge clk);
                #1;
                foreach (bytes[i]) send_frame(bytes[i], 1'b1, BIT_T);
            end
            begin
                foreach (bytes[i]) begin
                    wait_avail(2 * 10 * BIT_CLK, ok);
                    check("t2_arrived", ok, 1'b1);
                    model_deliver(bytes[i], 0);
                    check("t2_data", data, exp_data);
                    check("t2_ovr", ovr, 1'b0);
                    do_ack(); model_ack();
                end
            end
        join
        check_model("t2_end");
        check("t2_ferr", fe_cnt, 0);

        // 3. start glitch rejection
        repeat (20) @(posedge clk);
        @(posedge clk);
        #1 rx = 1'b0;
        #(BIT_T * 20.0 / 104.167);
        rx = 1'b1;
        #(BIT_T * 0.75);
        check("t3_busy_clear", busy, 1'b0);
        check("t3_busy_seen", busy_seen, 1'b1);
        check("t3_no_avail", avail, 1'b0);
        send_at(8'h3C, 1'b1, BIT_T);
        model_deliver(8'h3C, 0);
        check_model("t3");
        do_ack(); model_ack();

        // 4. framing error, line held low, then recovery
        fe_cnt = 0; fe_long = 0;
        send_at(8'h81, 1'b0, BIT_T);
        @(negedge clk);
        check("t4_fe_pulses", fe_cnt, 1);
        check("t4_fe_single_clk", fe_long, 0);
        check("t4_no_avail", avail, 1'b0);
        busy_seen = 0;
        #(BIT_T * 10.0);
        check("t4_hold_no_busy", busy_seen, 1'b0);
        check("t4_hold_no_avail", avail, 1'b0);
        rx = 1'b1;
        #(BIT_T * 2.0);
        send_at(8'h42, 1'b1, BIT_T);
        model_deliver(8'h42, 0);
        check_model("t4");
        check("t4_fe_total", fe_cnt, 1);
        do_ack(); model_ack();

        // 5. overrun, then ack coinciding with delivery
        send_at(8'h11, 1'b1, BIT_T); model_deliver(8'h11, 0);
        send_at(8'h22, 1'b1, BIT_T); model_deliver(8'h22, 0);
        check_model("t5_ovr");
        do_ack(); model_ack();
        check_model("t5_ack");
        send_at(8'h11, 1'b1, BIT_T); model_deliver(8'h11, 0);
        fork
            send_at(8'h22, 1'b1, BIT_T);
            begin
                @(posedge clk);
                repeat (SYNC_CLKS + (9 * 16 + 9) * TD) @(posedge clk);
                #1 ack = 1'b1;
                @(posedge clk);
                #1 ack = 1'b0;
            end
        join
        model_deliver(8'h22, 1);
        check_model("t5_coincide");
        do_ack(); model_ack();
        check_model("t5_coincide_ack");

        // random bytes with random consumer behaviour
        for (int k = 0; k < 8; k++) begin
            b = 8'($urandom);
            ack_now = 1'($urandom_range(0, 1));
            send_at(b, 1'b1, BIT_T);
            model_deliver(b, 0);
            check_model("rnd");
            if (ack_now) begin
                do_ack(); model_ack();
                check_model("rnd_ack");
            end
        end

        // 6. reset mid-frame with line low, then +/-2% baud
        send_at(8'h5A, 1'b1, BIT_T); model_deliver(8'h5A, 0);
        send_at(8'h6B, 1'b1, BIT_T); model_deliver(8'h6B, 0);
        check_model("t6_pending");
        @(posedge clk);
        #1 rx = 1'b0;
        #(BIT_T);
        rx = 1'b1; #(BIT_T);
        rx = 1'b0; #(BIT_T);
        rx = 1'b0; #(BIT_T);
        rx = 1'b1; #(BIT_T * 0.5);
        check("t6_busy_mid", busy, 1'b1);
        rx = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        model_reset();
        check_model("t6_reset");
        check("t6_reset_busy", busy, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        fe_cnt = 0; busy_seen = 0;
        #(BIT_T * 2.0);
        check("t6_low_no_busy", busy_seen, 1'b0);
        check("t6_low_no_fe", fe_cnt, 0);
        rx = 1'b1;
        #(BIT_T * 2.0);
        send_at(8'h77, 1'b1, BIT_T / 1.02);
        #(BIT_T * 0.2);
        model_deliver(8'h77, 0);
        check_model("t6_fast");
        do_ack(); model_ack();
        #(BIT_T);
        send_at(8'h77, 1'b1, BIT_T / 0.98);
        model_deliver(8'h77, 0);
        check_model("t6_slow");
        do_ack(); model_ack();
        check_model("t6_end");
        check("t6_fe_none", fe_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
